exp_stream_controller: RTL
==========================

Name: exp_stream_controller

Overview:
- Sequencer for the exponential-engine datapath (shift register, Ui register, exponential engine, combinational output shifter).
- Pulls (Vo, Ui) words from an upstream show-ahead FIFO and loads them into the datapath.
- Runs the exponential engine once per 2-bit slice, shifting the input register between runs.
- Pushes each 21-bit wr_data result into a downstream FIFO. Frame-based: one start processes FRAME_WORDS input words.

Parameters:
FRAME_WORDS, 4, input words per frame (>=1)
SLICES_PER_WORD, 8, engine runs per loaded word; shiftL pulses = SLICES_PER_WORD-1 per word
TIMEOUT_CYC, 255, engDone watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse starting a frame; ignored unless idle
in_empty  in  1  upstream FIFO empty
in_rd  out  1  upstream FIFO pop; Vo/Ui valid on FIFO outputs in the same cycle
out_full  in  1  downstream FIFO full
out_wr  out  1  downstream FIFO push of wr_data
Ldx  out  1  load Vo into the datapath shift register
Ldu  out  1  load Ui into the datapath Ui register
shiftL  out  1  shift the datapath shift register one slice
engStart  out  1  one-cycle engine start pulse
engDone  in  1  engine completion; first high cycle in WAIT counts
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse when the frame completes
word_cnt  out  $clog2(FRAME_WORDS+1)  words completed in the current frame
err  out  1  watchdog error (sticky; forced 0 without the optional feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counters 0.
- All control outputs are Moore-decoded from registered state.
- IDLE: busy=0. On start=1, go to FETCH, clear word_cnt and slice_cnt.
- FETCH: wait while in_empty=1. When in_empty=0, go to LOAD.
- LOAD (1 cycle): Ldx=Ldu=in_rd=1, then go to START.
- START (1 cycle): engStart=1, then go to WAIT.
- WAIT: hold until engDone=1, then go to WRITE. engDone is ignored in every other state.
- WRITE: out_wr=1 only when out_full=0; stay in WRITE while full.
  - On the push, if slice_cnt=SLICES_PER_WORD-1: clear slice_cnt, increment word_cnt.
    - If word_cnt reaches FRAME_WORDS, go to DONE.
    - Otherwise go to FETCH.
  - Else increment slice_cnt and go to SHIFT.
- SHIFT (1 cycle): shiftL=1, then go to START.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. word_cnt holds until the next start.
- busy=1 in every state except IDLE and DONE.
- Latency per slice, with no backpressure and engine latency E: START(1) + WAIT(E) + WRITE(1) + SHIFT(1).
- start during busy: ignored, no queuing.
- start and engDone in the same cycle: start ignored unless in IDLE.
- rst asserted mid-frame: immediate abort to IDLE. The datapath is not flushed; the next frame reloads it via LOAD.
- Upstream empty mid-frame: stall in FETCH indefinitely; no timeout.
- in_rd and out_wr never assert together. Ldx/Ldu only assert in LOAD.

Optional Feature:
- Macro EXP_CTRL_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT. If it reaches TIMEOUT_CYC without engDone, set err=1 (sticky until reset), go to DONE, and pulse done.
  - word_cnt reports completed words only.
- Undefined:
  - No counter; WAIT waits forever.
  - err tied to 0.

Decomposition:
- Shared package exp_ctrl_pkg:
  - state enum (IDLE, FETCH, LOAD, START, WAIT, WRITE, SHIFT, DONE)
  - default FRAME_WORDS/SLICES_PER_WORD constants
  - RESULT_W=21, VO_W=16, UI_W=2
- No sub-module required.
- The optional watchdog counter may be a small sub-module exp_ctrl_watchdog, instantiated only under EXP_CTRL_WATCHDOG_EN.

Test Plan:
- Reset then idle: rst=0 with start=1 -> all outputs 0; after rst=1 with no start, busy stays 0.
- Nominal frame, FRAME_WORDS=2, SLICES_PER_WORD=3, engDone 5 cycles after engStart, no stalls -> 2 in_rd, 6 engStart, 4 shiftL, 6 out_wr; done one cycle after the 6th out_wr; word_cnt=2.
- Backpressure: out_full=1 for 10 cycles at the first WRITE -> out_wr stays 0 for those cycles, no extra engStart, exactly 1 push after release.
- Upstream empty: in_empty=1 for 7 cycles before word 2 -> stall in FETCH, in_rd pulses once after in_empty falls, sequence resumes.
- Abort: assert rst in WAIT mid-frame -> outputs 0 immediately; a new start runs a full frame with correct counts.
- Watchdog (EXP_CTRL_WATCHDOG_EN, TIMEOUT_CYC=20): engDone never asserted -> err=1 and done pulse 20 cycles after engStart; err stays high until reset.

Source files
------------

// File: rtl/exp_ctrl_pkg.sv
// exp_ctrl_pkg: shared state encoding and default constants for the
// exponential-engine stream controller.
package exp_ctrl_pkg;

  localparam int unsigned FRAME_WORDS_DEF     = 4;
  localparam int unsigned SLICES_PER_WORD_DEF = 8;
  localparam int unsigned TIMEOUT_CYC_DEF     = 255;

  localparam int unsigned RESULT_W = 21;
  localparam int unsigned VO_W     = 16;
  localparam int unsigned UI_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    WAIT,
    WRITE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/exp_ctrl_watchdog.sv
// exp_ctrl_watchdog: counts cycles while the engine run window is open
// (START plus WAIT) and flags expiry TIMEOUT_CYC cycles after engStart.
module exp_ctrl_watchdog
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter: cleared outside the run window, frozen once expired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run && (cnt_q >= LIMIT);

endmodule

// File: rtl/exp_stream_controller.sv
// exp_stream_controller: sequences FIFO pops, engine runs and result pushes
// for the exponential-engine datapath, one frame of FRAME_WORDS words per start.
// Optional engine watchdog: define EXP_CTRL_WATCHDOG_EN.
module exp_stream_controller
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WORDS     = FRAME_WORDS_DEF,
  parameter int unsigned SLICES_PER_WORD = SLICES_PER_WORD_DEF,
  parameter int unsigned TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
  localparam int unsigned WCW            = $clog2(FRAME_WORDS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_empty,
  output logic           in_rd,
  input  logic           out_full,
  output logic           out_wr,
  output logic           Ldx,
  output logic           Ldu,
  output logic           shiftL,
  output logic           engStart,
  input  logic           engDone,
  output logic           busy,
  output logic           done,
  output logic [WCW-1:0] word_cnt,
  output logic           err
);

  localparam int unsigned SCW = (SLICES_PER_WORD > 1) ? $clog2(SLICES_PER_WORD) : 1;
  localparam logic [SCW-1:0] SLICE_LAST = SCW'(SLICES_PER_WORD - 1);
  localparam logic [WCW-1:0] WORD_LAST  = WCW'(FRAME_WORDS - 1);

  if (FRAME_WORDS == 0 || SLICES_PER_WORD == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
    $error("exp_stream_controller: FRAME_WORDS, SLICES_PER_WORD and TIMEOUT_CYC must be >= 1");
  end

  state_e           state_q;
  logic [WCW-1:0]   word_q;
  logic [SCW-1:0]   slice_q;
  logic             wd_expired;

`ifdef EXP_CTRL_WATCHDOG_EN
  logic err_q;

  exp_ctrl_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    ((state_q == START) || (state_q == WAIT)),
    .expired(wd_expired)
  );

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  // Frame sequencer: state, slice/word counters and sticky watchdog error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      slice_q <= '0;
`ifdef EXP_CTRL_WATCHDOG_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            word_q  <= '0;
            slice_q <= '0;
          end
        end
        FETCH: if (!in_empty) state_q <= LOAD;
        LOAD:  state_q <= START;
        START: state_q <= WAIT;
        WAIT: begin
          if (engDone) begin
            state_q <= WRITE;
          end else if (wd_expired) begin
            state_q <= DONE;
`ifdef EXP_CTRL_WATCHDOG_EN
            err_q   <= 1'b1;
`endif
          end
        end
        WRITE: begin
          if (!out_full) begin
            if (slice_q == SLICE_LAST) begin
              slice_q <= '0;
              word_q  <= word_q + 1'b1;
              state_q <= (word_q == WORD_LAST) ? DONE : FETCH;
            end else begin
              slice_q <= slice_q + 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: state_q <= START;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore output decode; the push alone is qualified by downstream space.
  always_comb begin
    in_rd    = 1'b0;
    Ldx      = 1'b0;
    Ldu      = 1'b0;
    engStart = 1'b0;
    out_wr   = 1'b0;
    shiftL   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_rd = 1'b1;
        Ldx   = 1'b1;
        Ldu   = 1'b1;
      end
      START:   engStart = 1'b1;
      WRITE:   out_wr   = !out_full;
      SHIFT:   shiftL   = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
    busy = (state_q != IDLE) && (state_q != DONE);
  end

  assign word_cnt = word_q;

endmodule
